// File: rtl/sram_pkg.sv
// sram_pkg: shared state type and BDD node layout for the dual-port node store.
package sram_pkg;
    typedef enum logic {ST_CLEAR, ST_READY} sram_state_t;
    localparam int NODE_F0_W = 8;
    localparam int NODE_F1_W = 8;
    localparam int NODE_F2_W = 8;
    localparam int NODE_ID_W = 10;
    typedef struct packed {
        logic [NODE_F0_W-1:0] f0;
        logic [NODE_F1_W-1:0] f1;
        logic [NODE_F2_W-1:0] f2;
        logic [NODE_ID_W-1:0] id;
    } bdd_node_t;
    localparam int NODE_W = $bits(bdd_node_t);
endpackage

// File: rtl/sram_clear_ctrl.sv
// sram_clear_ctrl: clear/ready FSM that sweeps zeros over every word after reset or on request.
module sram_clear_ctrl import sram_pkg::*; #(
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  ready
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
    sram_state_t           state;
    logic [ADDR_WIDTH-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else if (state == ST_CLEAR) begin
            state <= (cnt == LAST) ? ST_READY : ST_CLEAR;
            cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end else if (clear) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end
    end
    assign clr_we   = state == ST_CLEAR;
    assign clr_addr = cnt;
    assign ready    = state == ST_READY;
endmodule

// File: rtl/sram_dp.sv
// sram_dp: simple-dual-port SRAM with registered read, clear sweep and range checks.
// Define SRAM_BYPASS_EN to forward same-cycle write data to a colliding read.
module sram_dp import sram_pkg::*; #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = NODE_W,
    parameter int DEPTH      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    input  logic                  i_clear,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_ready,
    output logic                  o_addr_err
);
    localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH + 1)'(DEPTH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  clr_we, acc, wr_in, rd_in, wr_ok, rd_ok;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0] rd_word;
    sram_clear_ctrl #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_ctrl (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .clear    (i_clear),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (o_ready)
    );
    // a clear request in READY swallows any port traffic of the same cycle
    assign acc   = o_ready & ~i_clear;
    assign wr_in = {1'b0, i_wr_addr} < LIM;
    assign rd_in = {1'b0, i_rd_addr} < LIM;
    assign wr_ok = acc & i_wr_en & wr_in;
    assign rd_ok = acc & i_rd_en;
`ifdef SRAM_BYPASS_EN
    assign rd_word = (wr_ok && i_wr_addr == i_rd_addr) ? i_wr_data : mem[i_rd_addr];
`else
    assign rd_word = mem[i_rd_addr];
`endif
    always_ff @(posedge i_clk) begin
        if (clr_we || wr_ok)
            mem[clr_we ? clr_addr : i_wr_addr] <= clr_we ? '0 : i_wr_data;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
            o_addr_err <= 1'b0;
        end else begin
            o_rd_valid <= rd_ok;
            o_addr_err <= (acc & i_wr_en & ~wr_in) | (rd_ok & ~rd_in);
            if (rd_ok)
                o_rd_data <= rd_in ? rd_word : '0;
        end
    end
endmodule

// File: tb/tb_sram_dp.sv
// tb_sram_dp: randomized self-checking bench for sram_dp at DEPTH 32 and DEPTH 20.
module tb_sram_dp;
    import sram_pkg::*;
`ifdef SRAM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        i_clk, i_rst_n, i_wr_en, i_rd_en, i_clear;
    logic [4:0]  i_wr_addr, i_rd_addr;
    logic [33:0] i_wr_data;
    logic [33:0] q_data [2];
    logic        q_valid [2], q_ready [2], q_err [2];
    logic [33:0] m [2][32];
    logic [33:0] e_data [2];
    logic        e_valid [2], e_err [2];
    int          left [2];
    int          dep [2] = '{32, 20};
    int          n_tests = 0, n_fail = 0;

    sram_dp #(.ADDR_WIDTH(5), .DATA_WIDTH(34), .DEPTH(32)) u_dut0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .i_clear(i_clear),
        .o_rd_data(q_data[0]), .o_rd_valid(q_valid[0]), .o_ready(q_ready[0]), .o_addr_err(q_err[0])
    );
    sram_dp #(.ADDR_WIDTH(5), .DATA_WIDTH(34), .DEPTH(20)) u_dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .i_clear(i_clear),
        .o_rd_data(q_data[1]), .o_rd_valid(q_valid[1]), .o_ready(q_ready[1]), .o_addr_err(q_err[1])
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [33:0] nd(input int a, input int b, input int c, input int id);
        bdd_node_t n;
        n.f0 = 8'(a);
        n.f1 = 8'(b);
        n.f2 = 8'(c);
        n.id = 10'(id);
        return n;
    endfunction

    // reference model: words, outstanding sweep cycles and expected registered outputs
    task automatic tick();
        for (int d = 0; d < 2; d++) begin
            if (!i_rst_n) begin
                left[d] = dep[d];
                e_valid[d] = 1'b0;
                e_err[d] = 1'b0;
                e_data[d] = '0;
                for (int k = 0; k < 32; k++) m[d][k] = '0;
            end else if (left[d] > 0) begin
                left[d]--;
                e_valid[d] = 1'b0;
                e_err[d] = 1'b0;
            end else if (i_clear) begin
                left[d] = dep[d];
                e_valid[d] = 1'b0;
                e_err[d] = 1'b0;
                for (int k = 0; k < 32; k++) m[d][k] = '0;
            end else begin
                bit wi, ri;
                wi = int'(i_wr_addr) < dep[d];
                ri = int'(i_rd_addr) < dep[d];
                e_valid[d] = i_rd_en;
                e_err[d] = (i_wr_en && !wi) || (i_rd_en && !ri);
                if (i_rd_en)
                    e_data[d] = !ri ? 34'd0 :
                                (BYP && i_wr_en && wi && i_wr_addr == i_rd_addr) ? i_wr_data :
                                m[d][i_rd_addr];
                if (i_wr_en && wi) m[d][i_wr_addr] = i_wr_data;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
        i_clear = 1'b0;
    endtask

    task automatic count_ready(input string name);
        int n = 0, n2 = 0;
        for (int k = 1; k <= 40 && n == 0; k++) begin
            tick();
            if (q_ready[1] && n2 == 0) n2 = k;
            if (q_ready[0]) n = k;
            if (k < 32) begin
                n_tests++;
                if ({q_valid[0], q_err[0]} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL %s_quiet edge %0d got valid/err %b%b required 00", name, k, q_valid[0], q_err[0]);
                end
            end
        end
        n_tests++;
        if (n !== 32) begin
            n_fail++;
            $display("FAIL %s_edges32 got %0d required 32", name, n);
        end
        n_tests++;
        if (n2 !== 20) begin
            n_fail++;
            $display("FAIL %s_edges20 got %0d required 20", name, n2);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        idle();
        i_wr_addr = '0;
        i_rd_addr = '0;
        i_wr_data = '0;
        #2;
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if ({q_data[d], q_valid[d], q_ready[d], q_err[d]} !== 37'd0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d got %h/%b%b%b required 0", d, q_data[d], q_valid[d], q_ready[d], q_err[d]);
            end
        end
        tick();
        tick();
        i_rst_n = 1'b1;
        count_ready("reset");
        n_tests++;
        if (q_data[0] !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_data got %h required 0", q_data[0]);
        end
    endtask

    task automatic test_write_read();
        logic [33:0] nodes [8];
        nodes = '{nd(100,0,0,245), nd(0,100,0,175), nd(100,0,0,495), nd(100,0,0,485),
                  nd(0,100,0,165), nd(0,100,0,155), nd(0,0,100,595), nd(0,0,100,695)};
        for (int a = 0; a < 8; a++) begin
            i_wr_en = 1'b1;
            i_wr_addr = 5'(a);
            i_wr_data = nodes[a];
            tick();
        end
        i_wr_en = 1'b0;
        for (int a = 0; a < 9; a++) begin
            i_rd_en = 1'b1;
            i_rd_addr = (a == 8) ? 5'd9 : 5'(a);
            tick();
            n_tests++;
            if (q_valid[0] !== 1'b1 || q_data[0] !== ((a == 8) ? 34'd0 : nodes[a])) begin
                n_fail++;
                $display("FAIL read_back addr %0d got %b/%h required 1/%h", i_rd_addr, q_valid[0], q_data[0], (a == 8) ? 34'd0 : nodes[a]);
            end
            n_tests++;
            if (q_data[1] !== e_data[1] || q_valid[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL read_back20 addr %0d got %b/%h required 1/%h", i_rd_addr, q_valid[1], q_data[1], e_data[1]);
            end
        end
        idle();
        tick();
        n_tests++;
        if (q_valid[0] !== 1'b0 || q_data[0] !== 34'd0) begin
            n_fail++;
            $display("FAIL read_hold got %b/%h required 0/0", q_valid[0], q_data[0]);
        end
    endtask

    task automatic test_collision();
        logic [33:0] want;
        want = BYP ? nd(0,0,100,695) : nd(100,0,0,485);
        i_wr_en = 1'b1;
        i_wr_addr = 5'd3;
        i_wr_data = nd(0,0,100,695);
        i_rd_en = 1'b1;
        i_rd_addr = 5'd3;
        tick();
        idle();
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (q_valid[d] !== 1'b1 || q_data[d] !== want) begin
                n_fail++;
                $display("FAIL collision dut%0d got %b/%h required 1/%h", d, q_valid[d], q_data[d], want);
            end
        end
        i_rd_en = 1'b1;
        tick();
        idle();
        n_tests++;
        if (q_data[0] !== nd(0,0,100,695)) begin
            n_fail++;
            $display("FAIL collision_commit got %h required %h", q_data[0], nd(0,0,100,695));
        end
    endtask

    task automatic test_out_of_range();
        i_wr_en = 1'b1;
        i_wr_addr = 5'd5;
        i_wr_data = 34'h2_5A5A_1234;
        tick();
        i_wr_addr = 5'd25;
        i_wr_data = 34'h1_FFFF_0000;
        tick();
        idle();
        n_tests++;
        if (q_err[1] !== 1'b1 || q_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_write_err got %b/%b required 1/0", q_err[1], q_err[0]);
        end
        tick();
        n_tests++;
        if (q_err[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_err_pulse got %b required 0", q_err[1]);
        end
        i_rd_en = 1'b1;
        i_rd_addr = 5'd31;
        tick();
        idle();
        n_tests++;
        if ({q_valid[1], q_err[1]} !== 2'b11 || q_data[1] !== 34'd0) begin
            n_fail++;
            $display("FAIL oor_read got %b%b/%h required 11/0", q_valid[1], q_err[1], q_data[1]);
        end
        tick();
        n_tests++;
        if (q_err[1] !== 1'b0 || q_valid[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_read_pulse got %b%b required 00", q_valid[1], q_err[1]);
        end
        i_rd_en = 1'b1;
        i_rd_addr = 5'd5;
        tick();
        idle();
        n_tests++;
        if (q_data[1] !== 34'h2_5A5A_1234) begin
            n_fail++;
            $display("FAIL oor_alias got %h required %h", q_data[1], 34'h2_5A5A_1234);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            i_wr_en = 1'($urandom_range(1, 0));
            i_rd_en = 1'($urandom_range(1, 0));
            i_wr_addr = 5'($urandom_range(31, 0));
            i_rd_addr = ($urandom_range(3, 0) == 0) ? i_wr_addr : 5'($urandom_range(31, 0));
            i_wr_data = 34'({$urandom(), $urandom()});
            tick();
            for (int d = 0; d < 2; d++) begin
                n_tests++;
                if ({q_ready[d], q_valid[d], q_err[d], q_data[d]} !== {1'b1, e_valid[d], e_err[d], e_data[d]}) begin
                    n_fail++;
                    $display("FAIL random dut%0d cycle %0d got %b%b%b/%h required 1%b%b/%h", d, c,
                             q_ready[d], q_valid[d], q_err[d], q_data[d], e_valid[d], e_err[d], e_data[d]);
                end
            end
        end
        idle();
        tick();
    endtask

    task automatic test_reclear();
        i_clear = 1'b1;
        i_wr_en = 1'b1;
        i_wr_addr = 5'd2;
        i_wr_data = 34'h3_1234_5678;
        i_rd_en = 1'b1;
        i_rd_addr = 5'd1;
        tick();
        idle();
        n_tests++;
        if ({q_ready[0], q_valid[0], q_err[0]} !== 3'b000) begin
            n_fail++;
            $display("FAIL reclear_drop got ready/valid/err %b%b%b required 000", q_ready[0], q_valid[0], q_err[0]);
        end
        count_ready("reclear");
        for (int a = 0; a < 8; a++) begin
            i_rd_en = 1'b1;
            i_rd_addr = 5'(a);
            tick();
            n_tests++;
            if (q_valid[0] !== 1'b1 || q_data[0] !== 34'd0 || q_data[1] !== e_data[1]) begin
                n_fail++;
                $display("FAIL reclear_zero addr %0d got %b/%h/%h required 1/0/%h", a, q_valid[0], q_data[0], q_data[1], e_data[1]);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid_clear();
        i_clear = 1'b1;
        tick();
        idle();
        for (int k = 0; k < 9; k++) tick();
        i_rd_en = 1'b1;
        i_rd_addr = 5'd4;
        tick();
        i_rst_n = 1'b0;
        idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if ({q_data[d], q_valid[d], q_ready[d], q_err[d]} !== 37'd0) begin
                n_fail++;
                $display("FAIL midclear_reset dut%0d got %h/%b%b%b required 0", d, q_data[d], q_valid[d], q_ready[d], q_err[d]);
            end
        end
        tick();
        tick();
        i_rst_n = 1'b1;
        count_ready("midclear");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_out_of_range();
        test_random();
        test_reclear();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
